memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Memory stage between execute and write-back/fetch. Turns one execute-stage load/store into 16-bit data-memory bus
//  transactions: word = two halfwords, low half first. Stalls upstream during the split. Streams raw read halfwords
//  plus a registered mem_to_reg flag and ALU result to write-back, which assembles 32-bit load data.
// PARAMETERS
//  ADDR_WIDTH  32  width of data address, addr_i and data_mem_addr_o
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  rst_i            in   1   synchronous active-high reset
//  valid_i          in   1   execute-stage op valid this cycle
//  mem_read_i       in   1   op is a load
//  mem_write_i      in   1   op is a store
//  size_i           in   2   0=byte 1=half 2=word 3=illegal
//  sext_i           in   1   sign-extend byte loads to 16 bit (else zero-extend)
//  addr_i           in   AW  effective byte address from ALU
//  wdata_i          in   32  store data
//  calc_i           in   32  ALU result, passed to write-back
//  data_mem_rdata_i in   16  read halfword, valid 1 cycle after data_mem_re_o
//  data_mem_addr_o  out  AW  halfword-aligned bus address
//  data_mem_wdata_o out  16  write halfword
//  data_mem_be_o    out  2   byte enables, [0]=low lane
//  data_mem_we_o    out  1   write strobe
//  data_mem_re_o    out  1   read strobe
//  stall_o          out  1   hold execute and earlier stages
//  data_read_o      out  16  load halfword to write-back
//  data_calc_o      out  32  registered calc_i
//  mem_to_reg_o     out  1   registered: data_read_o is load data this cycle
//  err_o            out  1   1-cycle pulse: illegal/misaligned op dropped
// BEHAVIOUR
//  Reset: state=ST_IDLE; all registered outputs 0; bus strobes, be, stall_o deasserted. Reset mid-word aborts; the
//   second half is never issued.
//  FSM ST_IDLE/ST_HIGH. Bus outputs are combinational from state + inputs (IDLE) or from latched op (ST_HIGH).
//  ST_IDLE, valid_i and exactly one of mem_read_i/mem_write_i:
//   illegal if size_i=3, or size>=1 with addr_i[0]=1 -> no strobe, err_o=1 next cycle, stay IDLE.
//   byte: addr={addr_i[AW-1:1],0}; be=addr_i[0]?2'b10:2'b01; store wdata={2{wdata_i[7:0]}}.
//   half: be=2'b11; wdata=wdata_i[15:0]. Byte/half complete in 1 cycle, stall_o=0.
//   word: issue low half (addr_i, be=11, wdata_i[15:0]); latch addr, wdata[31:16], op type;
//    stall_o=1; next ST_HIGH.
//  valid_i with both mem_read_i and mem_write_i -> illegal (err_o); with neither -> no bus access, pass-through.
//  ST_HIGH: addr=latched addr+2, be=11, wdata=latched high half, same strobe; stall_o=0; next ST_IDLE.
//   Inputs ignored in ST_HIGH (upstream held by stall). Address add wraps modulo 2^AW.
//  Registered to write-back every cycle: data_calc_o<=calc_i (held in ST_HIGH);
//   mem_to_reg_o<=data_mem_re_o; lane info (addr[0], size, sext) registered with it.
//  Read latency 1: data_read_o = data_mem_rdata_i when lane info says half/word; byte: select lane by
//   registered addr[0], extend per sext to 16 bit. Word load -> mem_to_reg_o high 2 consecutive
//   cycles: low half, then high half. Byte/half load -> 1 cycle.
//  Back-to-back: a new op accepted in the cycle after ST_HIGH; no bubble between single-cycle ops.
//  err_o, stores and non-memory ops never assert mem_to_reg_o.
// TESTING
//  Reset mid-word store (rst_i in ST_HIGH cycle) -> no addr+2 write, state IDLE, all outputs 0 next cycle.
//  Word load addr=0x100, mem[0x100]=0xBEEF, mem[0x102]=0xDEAD -> re at 0x100 then 0x102, stall_o 1 cycle,
//   mem_to_reg_o 2 cycles, data_read_o 0xBEEF then 0xDEAD.
//  Word store 0x12345678 to 0x200 -> we at 0x200 wdata 0x5678 be 11, then 0x202 wdata 0x1234 be 11.
//  Byte load sext=1 addr=0x301, mem[0x300]=0x80AA -> data_read_o=0xFF80; sext=0 -> 0x0080; 1 mem_to_reg cycle.
//  Byte store 0x5A to 0x401 -> addr 0x400, be 10, wdata 0x5A5A, no stall.
//  Half load addr=0x103 or size=3 -> no strobe, err_o pulse 1 cycle, mem_to_reg_o=0; next op proceeds.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage splitting loads/stores into 16-bit data-memory bus transactions
module memory_access #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           calc_i,
  input  logic [15:0]           data_mem_rdata_i,
  output logic [ADDR_WIDTH-1:0] data_mem_addr_o,
  output logic [15:0]           data_mem_wdata_o,
  output logic [1:0]            data_mem_be_o,
  output logic                  data_mem_we_o,
  output logic                  data_mem_re_o,
  output logic                  stall_o,
  output logic [15:0]           data_read_o,
  output logic [31:0]           data_calc_o,
  output logic                  mem_to_reg_o,
  output logic                  err_o
);

  typedef enum logic {ST_IDLE, ST_HIGH} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   hi_addr;
  logic [15:0]             hi_wdata;
  logic                    hi_write;
  logic                    one_op;
  logic                    illegal;
  logic                    accept;
  logic                    is_word;
  logic                    lane_addr0;
  logic [1:0]              lane_size;
  logic                    lane_sext;
  logic [7:0]              rbyte;

  // Exactly one of read/write makes a memory op; both at once is always illegal,
  // neither is a pass-through that only forwards calc_i.
  assign one_op  = mem_read_i ^ mem_write_i;
  assign illegal = valid_i & ((mem_read_i & mem_write_i) |
                   (one_op & ((size_i == 2'd3) | ((size_i != 2'd0) & addr_i[0]))));
  assign accept  = valid_i & one_op & ~illegal;
  assign is_word = accept & (size_i == 2'd2);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Capture the second half of a word op; the +2 is folded in here so ST_HIGH drives it directly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_addr  <= '0;
      hi_wdata <= '0;
      hi_write <= 1'b0;
    end else if (state == ST_IDLE && is_word) begin
      hi_addr  <= addr_i + ADDR_WIDTH'(2);
      hi_wdata <= wdata_i[31:16];
      hi_write <= mem_write_i;
    end
  end

  // Next state and bus drive; reset gates the strobes so a pending high half is never issued
  always_comb begin
    state_next       = state;
    data_mem_addr_o  = '0;
    data_mem_wdata_o = '0;
    data_mem_be_o    = 2'b00;
    data_mem_we_o    = 1'b0;
    data_mem_re_o    = 1'b0;
    stall_o          = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_mem_addr_o = {addr_i[ADDR_WIDTH-1:1], 1'b0};
            data_mem_re_o   = mem_read_i;
            data_mem_we_o   = mem_write_i;
            if (size_i == 2'd0) begin
              data_mem_be_o    = addr_i[0] ? 2'b10 : 2'b01;
              data_mem_wdata_o = {2{wdata_i[7:0]}};
            end else begin
              data_mem_be_o    = 2'b11;
              data_mem_wdata_o = wdata_i[15:0];
            end
            if (is_word) begin
              stall_o    = 1'b1;
              state_next = ST_HIGH;
            end
          end
        end
        ST_HIGH: begin
          data_mem_addr_o  = hi_addr;
          data_mem_be_o    = 2'b11;
          data_mem_wdata_o = hi_wdata;
          data_mem_we_o    = hi_write;
          data_mem_re_o    = ~hi_write;
          state_next       = ST_IDLE;
        end
      endcase
    end
  end

  // Write-back pipeline register: calc, load flag, lane info for the returning halfword, error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_calc_o  <= '0;
      mem_to_reg_o <= 1'b0;
      err_o        <= 1'b0;
      lane_addr0   <= 1'b0;
      lane_size    <= 2'd0;
      lane_sext    <= 1'b0;
    end else begin
      if (state == ST_IDLE) data_calc_o <= calc_i;
      mem_to_reg_o <= data_mem_re_o;
      err_o        <= (state == ST_IDLE) & illegal;
      lane_addr0   <= (state == ST_IDLE) & addr_i[0];
      lane_size    <= (state == ST_HIGH) ? 2'd2 : size_i;
      lane_sext    <= sext_i;
    end
  end

  // Returning halfword: bytes pick their lane and extend, halves/words pass straight through
  always_comb begin
    rbyte       = lane_addr0 ? data_mem_rdata_i[15:8] : data_mem_rdata_i[7:0];
    data_read_o = '0;
    if (mem_to_reg_o) begin
      if (lane_size == 2'd0) data_read_o = {{8{lane_sext & rbyte[7]}}, rbyte};
      else                   data_read_o = data_mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - bench for memory_access against a byte-addressed memory model
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] calc;
  logic [15:0] rdata;
  logic [31:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_be;
  logic        bus_we;
  logic        bus_re;
  logic        stall;
  logic [15:0] data_read;
  logic [31:0] data_calc;
  logic        mem_to_reg;
  logic        err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [15:0] smem [0:2047];
  logic [7:0]  rmem [0:4095];
  bit          loaded;

  always #5 clk = ~clk;

  memory_access #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .size_i(size), .sext_i(sext), .addr_i(addr_in), .wdata_i(wdata_in), .calc_i(calc),
    .data_mem_rdata_i(rdata), .data_mem_addr_o(bus_addr), .data_mem_wdata_o(bus_wdata),
    .data_mem_be_o(bus_be), .data_mem_we_o(bus_we), .data_mem_re_o(bus_re), .stall_o(stall),
    .data_read_o(data_read), .data_calc_o(data_calc), .mem_to_reg_o(mem_to_reg), .err_o(err)
  );

  function automatic logic [15:0] fill(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  // Halfword bus slave with byte enables and one-cycle read latency
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) smem[i] <= fill(i);
      loaded <= 1'b1;
    end else if (bus_we) begin
      if (bus_be[0]) smem[bus_addr[11:1]][7:0]  <= bus_wdata[7:0];
      if (bus_be[1]) smem[bus_addr[11:1]][15:8] <= bus_wdata[15:8];
    end
    rdata <= (bus_re && loaded) ? smem[bus_addr[11:1]] : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One execute-stage op, starting at a negedge in IDLE; expectations come from the byte model
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] cl);
    logic        bad, acc, word;
    logic [1:0]  ebe;
    logic [15:0] ewd, ld, hi;
    logic [11:0] b;
    b    = a[11:0];
    bad  = (rd & wr) | ((rd ^ wr) & ((sz == 2'd3) | ((sz != 2'd0) & a[0])));
    acc  = (rd ^ wr) & !bad;
    word = acc & (sz == 2'd2);
    ebe  = (sz == 2'd0) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    ewd  = (sz == 2'd0) ? {wd[7:0], wd[7:0]} : wd[15:0];
    if (sz == 2'd0) ld = sx ? {{8{rmem[b][7]}}, rmem[b]} : {8'h00, rmem[b]};
    else            ld = {rmem[b + 12'd1], rmem[b]};
    hi = {rmem[b + 12'd3], rmem[b + 12'd2]};
    valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; sext = sx;
    addr_in = a; wdata_in = wd; calc = cl;
    #1;
    check("re", bus_re, acc & rd);
    check("we", bus_we, acc & wr);
    check("stall", stall, word);
    if (acc) begin
      check("addr", bus_addr, {a[31:1], 1'b0});
      check("be", bus_be, ebe);
      if (wr) check("wdata", bus_wdata, ewd);
    end
    @(negedge clk);
    check("err", err, bad);
    check("calc", data_calc, cl);
    check("m2r", mem_to_reg, acc & rd);
    if (acc & rd) check("rd_lo", data_read, ld);
    if (word) begin
      check("hi_addr", bus_addr, a + 32'd2);
      check("hi_be", bus_be, 2'b11);
      check("hi_re", bus_re, rd);
      check("hi_we", bus_we, wr);
      check("hi_stall", stall, 1'b0);
      if (wr) check("hi_wdata", bus_wdata, wd[31:16]);
      @(negedge clk);
      check("hi_m2r", mem_to_reg, rd);
      if (rd) check("rd_hi", data_read, hi);
      check("hi_calc", data_calc, cl);
      check("hi_err", err, 1'b0);
    end
    if (acc & wr) begin
      rmem[b] = wd[7:0];
      if (sz != 2'd0) rmem[b + 12'd1] = wd[15:8];
      if (sz == 2'd2) begin
        rmem[b + 12'd2] = wd[23:16];
        rmem[b + 12'd3] = wd[31:24];
      end
    end
  endtask

  task automatic idle();
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, bus_we, 1'b0);
    check({tag, "_re"}, bus_re, 1'b0);
    check({tag, "_be"}, bus_be, 2'b00);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_m2r"}, mem_to_reg, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_calc"}, data_calc, 32'h0);
    check({tag, "_rdata"}, data_read, 16'h0);
  endtask

  initial begin
    logic [31:0] ra, rw;
    int          kind;
    for (int i = 0; i < 2048; i++) {rmem[2*i+1], rmem[2*i]} = fill(i);
    rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0; sext = 1'b0;
    addr_in = '0; wdata_in = '0; calc = 32'h1111_2222;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Seed the directed locations through half stores
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h100, 32'h0000_BEEF, 32'h1);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_DEAD, 32'h2);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h300, 32'h0000_80AA, 32'h3);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h4);
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678, 32'h5);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h6);
    do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h301, 32'h0, 32'h7);
    do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 32'h8);
    do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h401, 32'h0000_005A, 32'h9);
    do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h400, 32'h0, 32'hA);
    do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'hB);
    do_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'hC);
    do_op(1'b1, 1'b1, 2'd1, 1'b0, 32'h100, 32'h0, 32'hD);
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hE);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hF);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h10);

    // Reset lands in the high-half cycle of a word store
    valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd2; addr_in = 32'h500;
    wdata_in = 32'hCAFE_F00D; calc = 32'h77;
    #1;
    check("mw_we", bus_we, 1'b1);
    check("mw_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mw_rst_we", bus_we, 1'b0);
    check("mw_rst_stall", stall, 1'b0);
    rmem[12'h500] = 8'h0D;
    rmem[12'h501] = 8'hF0;
    valid = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("mw_after");
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h20);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      ra   = 32'h600 + 32'($urandom_range(0, 511));
      rw   = $urandom;
      do_op(kind < 4 || kind == 8, (kind >= 4 && kind < 8) || kind == 8,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rw, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
